// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: FSM states, access-size
// encodings and the size-to-byte-count mapping.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Encoding 3 is not a real size and is handled as a word.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-requester grant (fetch vs load/store), combinational grant, pointer registered.
// MEM_CTRL_LS_PRIORITY_EN: load/store always wins; otherwise round-robin on contention.
module mem_ctrl_arb (
    input  logic clk_in,
    input  logic rst_in,
    input  logic if_req,
    input  logic ls_req,
    input  logic take,
    output logic gnt_vld,
    output logic gnt_ls
);

    assign gnt_vld = if_req | ls_req;

`ifdef MEM_CTRL_LS_PRIORITY_EN
    assign gnt_ls = ls_req;

    logic unused_arb;
    assign unused_arb = &{1'b0, clk_in, rst_in, take};
`else
    logic ptr_ls_q;
    logic ptr_ls_d;

    // The pointer names the port that wins the next contention; it moves
    // only when a contended grant is actually taken.
    always_comb begin
        gnt_ls   = ls_req & (~if_req | ptr_ls_q);
        ptr_ls_d = ptr_ls_q;
        if (take && if_req && ls_req) begin
            ptr_ls_d = ~gnt_ls;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_ls_q <= 1'b0;
        end else begin
            ptr_ls_q <= ptr_ls_d;
        end
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: fetch/load/store as 1/2/4 byte accesses; read N+2, write N+1 cycles.
// Accepts only in IDLE with rdy_in high; arbitration mode set by MEM_CTRL_LS_PRIORITY_EN.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);
    import mem_ctrl_pkg::*;

    state_t                state_q, state_d;
    logic                  port_ls_q, port_ls_d;
    logic                  we_q, we_d;
    logic [1:0]            last_q, last_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            iss_q, iss_d;
    logic [1:0]            rcv_q, rcv_d;
    logic                  rcv_vld_q, rcv_vld_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_done_q, if_done_d;
    logic                  ls_done_q, ls_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;

    logic       gnt_vld;
    logic       gnt_ls;
    logic       accept;
    logic [2:0] nbytes;

    assign accept = (state_q == IDLE) && rdy_in && gnt_vld;
    assign nbytes = gnt_ls ? size_to_nbytes(ls_size) : 3'd4;

    mem_ctrl_arb u_arb (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .if_req  (if_req),
        .ls_req  (ls_req),
        .take    (accept),
        .gnt_vld (gnt_vld),
        .gnt_ls  (gnt_ls)
    );

    always_comb begin
        state_d    = state_q;
        port_ls_d  = port_ls_q;
        we_d       = we_q;
        last_d     = last_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        iss_d      = iss_q;
        rcv_d      = rcv_q;
        rcv_vld_d  = rcv_vld_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = 8'h00;
        mem_wr_d   = 1'b0;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_ls_d = gnt_ls;
                    we_d      = gnt_ls & ls_we;
                    last_d    = 2'(nbytes - 3'd1);
                    base_d    = gnt_ls ? ls_addr : if_addr;
                    wdata_d   = ls_wdata;
                    iss_d     = 2'd0;
                    rcv_d     = 2'd0;
                    rcv_vld_d = 1'b0;
                    rdata_d   = 32'h0;
                    mem_a_d   = base_d;
                    if (we_d) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = ls_wdata[7:0];
                        state_d    = WRITE;
                    end else begin
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                if (iss_q != last_q) begin
                    iss_d   = iss_q + 2'd1;
                    mem_a_d = base_q + ADDR_WIDTH'(iss_d);
                end
                // RAM data lags the address by one cycle, so capture starts one cycle late.
                rcv_vld_d = 1'b1;
                if (rcv_vld_q) begin
                    rdata_d[{rcv_q, 3'b000} +: 8] = mem_din;
                    rcv_d = rcv_q + 2'd1;
                    if (rcv_q == last_q) begin
                        state_d   = DONE;
                        rcv_vld_d = 1'b0;
                        if (port_ls_q) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = rdata_d;
                        end else begin
                            if_done_d  = 1'b1;
                            if_data_d  = rdata_d;
                        end
                    end
                end
            end
            WRITE: begin
                if (iss_q == last_q) begin
                    state_d   = DONE;
                    ls_done_d = 1'b1;
                end else begin
                    iss_d      = iss_q + 2'd1;
                    mem_a_d    = base_q + ADDR_WIDTH'(iss_d);
                    mem_wr_d   = 1'b1;
                    mem_dout_d = wdata_q[{iss_d, 3'b000} +: 8];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            port_ls_q  <= 1'b0;
            we_q       <= 1'b0;
            last_q     <= 2'd0;
            base_q     <= '0;
            wdata_q    <= 32'h0;
            iss_q      <= 2'd0;
            rcv_q      <= 2'd0;
            rcv_vld_q  <= 1'b0;
            rdata_q    <= 32'h0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'h0;
            ls_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            port_ls_q  <= port_ls_d;
            we_q       <= we_d;
            last_q     <= last_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            iss_q      <= iss_d;
            rcv_q      <= rcv_d;
            rcv_vld_q  <= rcv_vld_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural synchronous-read byte RAM, scoreboard of expected
// completions (port, data, latency) checked as done pulses appear.
`timescale 1ns/1ps
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW = 17;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [31:0]   if_data;
    logic          ls_req;
    logic          ls_we;
    logic [1:0]    ls_size;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_done;
    logic [31:0]   ls_rdata;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    // RAM model with a backdoor write port used for preloading while the DUT is idle.
    logic [7:0]    ram [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_data;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a];
        if (mem_wr) ram[mem_a] <= mem_dout;
        else if (bd_we) ram[bd_addr] <= bd_data;
    end

    typedef struct {
        bit          ls;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk_in);
        bd_we = 1'b0;
    endtask

    // Entered and left on a negedge with the DUT idle.
    task automatic run_txn(input bit rif, input bit rls, input bit exp_ls, input bit we,
                           input int n, input logic [AW-1:0] base, input logic [31:0] wd,
                           input logic [31:0] exp_data, input string name);
        exp_t          e;
        bit            seen;
        logic [AW-1:0] ea;
        logic          exp_wr;
        logic [7:0]    exp_dout;
        logic [31:0]   got;
        sb.push_back('{exp_ls, exp_data, we ? n + 1 : n + 2});
        if_req = rif;
        ls_req = rls;
        @(posedge clk_in);
        seen = 0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                if_req   = 1'b0;
                ls_req   = 1'b0;
                if_addr  = AW'($urandom);
                ls_addr  = AW'($urandom);
                ls_wdata = $urandom;
                ls_size  = 2'($urandom);
                ls_we    = 1'($urandom);
                rdy_in   = 1'($urandom);
            end
            ea = base + AW'(k - 1);
            if (k <= n) begin
                n_checks++;
                if (mem_a !== ea) begin
                    n_fail++;
                    $display("FAIL %s mem_a cycle T+%0d: got %h want %h", name, k, mem_a, ea);
                end
            end
            exp_wr   = we && (k <= n);
            exp_dout = 8'h00;
            if (exp_wr) exp_dout = wd[8*(k-1) +: 8];
            n_checks++;
            if ({mem_wr, mem_dout} !== {exp_wr, exp_dout}) begin
                n_fail++;
                $display("FAIL %s mem_wr/dout cycle T+%0d: got %b/%h want %b/%h",
                         name, k, mem_wr, mem_dout, exp_wr, exp_dout);
            end
            if (if_done || ls_done) begin
                seen = 1;
                e = sb.pop_front();
                n_checks++;
                if ({if_done, ls_done} !== {~e.ls, e.ls}) begin
                    n_fail++;
                    $display("FAIL %s port: got if_done=%b ls_done=%b want ls=%0d",
                             name, if_done, ls_done, e.ls);
                end
                n_checks++;
                if (k != e.lat) begin
                    n_fail++;
                    $display("FAIL %s latency: got T+%0d want T+%0d", name, k, e.lat);
                end
                if (!we) begin
                    got = e.ls ? ls_rdata : if_data;
                    n_checks++;
                    if (got !== e.data) begin
                        n_fail++;
                        $display("FAIL %s data: got %h want %h", name, got, e.data);
                    end
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done pulse within 12 cycles", name);
            void'(sb.pop_back());
        end
        @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b1;
        n_checks++;
        if ({if_done, ls_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s done width: got %b%b want 00", name, if_done, ls_done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        n_checks++;
        if ({mem_wr, mem_dout, mem_a} !== '0) begin
            n_fail++;
            $display("FAIL reset mem: got wr=%b dout=%h a=%h want 0", mem_wr, mem_dout, mem_a);
        end
        n_checks++;
        if ({if_done, ls_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset done: got %b%b want 00", if_done, ls_done);
        end
        n_checks++;
        if ({if_data, ls_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset data: got %h/%h want 0", if_data, ls_rdata);
        end
        rst_in = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_fetch();
        poke(17'h100, 8'h13); poke(17'h101, 8'h00); poke(17'h102, 8'h00); poke(17'h103, 8'h00);
        if_addr = 17'h100;
        run_txn(1, 0, 0, 0, 4, 17'h100, 32'h0, 32'h0000_0013, "fetch");
    endtask

    task automatic test_store_wrap();
        logic [31:0]   wd;
        logic [AW-1:0] a;
        wd       = 32'hDEAD_BEEF;
        ls_we    = 1'b1;
        ls_size  = SZ_WORD;
        ls_addr  = 17'h1FFFE;
        ls_wdata = wd;
        run_txn(0, 1, 1, 1, 4, 17'h1FFFE, wd, 32'h0, "store_wrap");
        for (int i = 0; i < 4; i++) begin
            a = 17'h1FFFE + AW'(i);
            n_checks++;
            if (ram[a] !== wd[8*i +: 8]) begin
                n_fail++;
                $display("FAIL store_wrap ram[%h]: got %h want %h", a, ram[a], wd[8*i +: 8]);
            end
        end
        ls_we   = 1'b0;
        ls_size = SZ_WORD;
        ls_addr = 17'h1FFFE;
        run_txn(0, 1, 1, 0, 4, 17'h1FFFE, 32'h0, wd, "load_wrap");
    endtask

    task automatic test_load();
        poke(17'h201, 8'h80); poke(17'h202, 8'hFF); poke(17'h203, 8'h12); poke(17'h204, 8'h34);
        ls_we = 1'b0; ls_size = SZ_HALF; ls_addr = 17'h201;
        run_txn(0, 1, 1, 0, 2, 17'h201, 32'h0, 32'h0000_FF80, "load_half");
        ls_we = 1'b0; ls_size = SZ_BYTE; ls_addr = 17'h201;
        run_txn(0, 1, 1, 0, 1, 17'h201, 32'h0, 32'h0000_0080, "load_byte");
        ls_we = 1'b0; ls_size = 2'd3; ls_addr = 17'h201;
        run_txn(0, 1, 1, 0, 4, 17'h201, 32'h0, 32'h3412_FF80, "load_size3");
        n_checks++;
        if (if_data !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL if_data hold: got %h want 00000013", if_data);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_ls;
        for (int i = 0; i < 4; i++) begin
            poke(17'h500 + AW'(i), 8'(8'h01 + i));
            poke(17'h600 + AW'(i), 8'(8'hA1 + i));
        end
        for (int i = 0; i < 3; i++) begin
`ifdef MEM_CTRL_LS_PRIORITY_EN
            exp_ls = 1'b1;
`else
            exp_ls = (i == 1);
`endif
            if_addr = 17'h500; ls_addr = 17'h600; ls_we = 1'b0; ls_size = SZ_WORD;
            run_txn(1, 1, exp_ls, 0, 4, exp_ls ? 17'h600 : 17'h500, 32'h0,
                    exp_ls ? 32'hA4A3_A2A1 : 32'h0403_0201, "contend");
        end
    endtask

    task automatic test_reset_mid();
        poke(17'h40, 8'h11); poke(17'h41, 8'h22); poke(17'h42, 8'h33); poke(17'h43, 8'h44);
        ls_we = 1'b1; ls_size = SZ_WORD; ls_addr = 17'h40; ls_wdata = 32'hA5B6_C7D8;
        ls_req = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        ls_req = 1'b0;
        repeat (2) @(negedge clk_in);
        n_checks++;
        if ({mem_wr, mem_a} !== {1'b1, 17'h42}) begin
            n_fail++;
            $display("FAIL rst_mid third byte: got wr=%b a=%h want 1/00042", mem_wr, mem_a);
        end
        rst_in = 1'b1;
        #1;
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid mem_wr drop: got %b want 0", mem_wr);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (i == 2) rst_in = 1'b0;
            n_checks++;
            if (ls_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid ls_done: got %b want 0", ls_done);
            end
        end
        n_checks++;
        if ({ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]} !== 32'hD8C7_3344) begin
            n_fail++;
            $display("FAIL rst_mid ram: got %h %h %h %h want d8 c7 33 44",
                     ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]);
        end
        ls_we = 1'b0; ls_size = SZ_WORD; ls_addr = 17'h40;
        run_txn(0, 1, 1, 0, 4, 17'h40, 32'h0, 32'h4433_C7D8, "after_rst");
    endtask

    task automatic test_rdy();
        rdy_in = 1'b0;
        ls_we = 1'b1; ls_size = SZ_BYTE; ls_addr = 17'h300; ls_wdata = 32'h0000_005A;
        ls_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            n_checks++;
            if ({mem_wr, ls_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL rdy_low: got wr=%b done=%b want 0/0", mem_wr, ls_done);
            end
        end
        rdy_in = 1'b1;
        run_txn(0, 1, 1, 1, 1, 17'h300, 32'h0000_005A, 32'h0, "rdy_store");
        n_checks++;
        if (ram[17'h300] !== 8'h5A) begin
            n_fail++;
            $display("FAIL rdy_store ram: got %h want 5a", ram[17'h300]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_in   = 1'b1;
        rdy_in   = 1'b0;
        if_req   = 1'b0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_size  = 2'd0;
        if_addr  = '0;
        ls_addr  = '0;
        ls_wdata = 32'h0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_data  = 8'h00;
        test_reset();
        test_fetch();
        test_store_wrap();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_rdy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
